// File: rtl/arith_pkg.sv
// ============================================================================
// arith_pkg
// Shared FSM state encoding, add/sub mode constants and sizing helper for
// the arithmetic blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;

  // Bits needed to hold any value in 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_addsub.sv
// ============================================================================
// addsub_n
// N-bit ripple-carry adder/subtractor: b is XORed with mode and mode is the
// carry-in, so mode=1 yields a - b in two's complement.
// Revision: 1.0
// ============================================================================
`default_nettype none

module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_mode,
  output logic [N-1:0] o_sum
);

  logic [N-1:0] w_bx;
  logic [N-1:0] w_c;

  assign w_bx   = i_b ^ {N{i_mode}};
  assign w_c[0] = i_mode;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ w_bx[i] ^ w_c[i];
    // The carry out of the top bit is not needed by any user.
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// seq_restoring_divider
// Multi-cycle restoring divider, one quotient bit per clock, start/done
// handshake. Define SIGNED_DIV_EN for two's-complement truncating division.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  // The partial remainder is always below the divisor between steps, so
  // WIDTH bits hold it; only the shifted trial value needs WIDTH+1.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_fin_quot;
  logic [WIDTH-1:0] w_fin_rem;

  assign w_a_sh = {r_a, r_q[WIDTH-1]};

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_mode (SUB_MODE),
    .o_sum  (w_sum)
  );

`ifdef SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic r_sgn_a;
  logic r_sgn_d;

  // Outside CALC the subtractor is idle and computes 0 - x for the
  // dividend magnitude (IDLE) or the quotient negation (FIN).
  always_comb begin
    w_add_a = '0;
    w_add_b = {dividend[WIDTH-1], dividend};
    if (r_state == CALC) begin
      w_add_a = w_a_sh;
      w_add_b = {1'b0, r_d};
    end else if (r_state == FIN) begin
      w_add_b = {1'b0, r_q};
    end
  end

  assign w_dvd_mag = dividend[WIDTH-1] ? w_sum[WIDTH-1:0] : dividend;
  assign w_dvs_mag = divisor[WIDTH-1] ? (~divisor + c_one) : divisor;

  assign w_fin_quot = r_dz ? '1 :
                      ((r_sgn_a ^ r_sgn_d) ? w_sum[WIDTH-1:0] : r_q);
  assign w_fin_rem  = r_dz    ? (r_sgn_a ? w_sum[WIDTH-1:0] : r_q) :
                      r_sgn_a ? (~r_a + c_one) : r_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sgn_a <= 1'b0;
      r_sgn_d <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sgn_a <= dividend[WIDTH-1];
      r_sgn_d <= divisor[WIDTH-1];
    end
  end
`else
  assign w_add_a    = w_a_sh;
  assign w_add_b    = {1'b0, r_d};
  assign w_dvd_mag  = dividend;
  assign w_dvs_mag  = divisor;
  assign w_fin_quot = r_dz ? '1 : r_q;
  assign w_fin_rem  = r_dz ? r_q : r_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = (divisor == '0) ? FIN : CALC;
      CALC: if (r_cnt == c_cnt_last) w_state_nxt = FIN;
      FIN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_dz   <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q    <= w_dvd_mag;
            r_a    <= '0;
            r_d    <= w_dvs_mag;
            r_cnt  <= '0;
            r_dz   <= (divisor == '0);
            r_quot <= '0;
            r_rem  <= '0;
          end
        end
        CALC: begin
          // A negative trial result restores the shifted remainder.
          r_a   <= w_sum[WIDTH] ? w_a_sh[WIDTH-1:0] : w_sum[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + c_cnt_one;
        end
        FIN: begin
          r_quot <= w_fin_quot;
          r_rem  <= w_fin_rem;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == FIN);
  assign quotient    = done ? w_fin_quot : r_quot;
  assign remainder   = done ? w_fin_rem : r_rem;
  assign div_by_zero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// tb_seq_restoring_divider
// Self-checking bench for seq_restoring_divider against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  localparam int W = 4;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference: plain integer division, all-ones quotient on zero divisor.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output int lat);
    int sa;
    int sb;
`ifdef SIGNED_DIV_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0; lat = W + 1;
    end
  endfunction

  // Runs one operation starting in an IDLE cycle; returns the FIN-cycle
  // outputs and leaves the bench in the cycle after done.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < TMO) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done %b, want 00", {busy, done});
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r, eq, er;
    logic dz, edz;
    int lat, elat, bc;
    issue(4'd11, 4'd3, q, r, dz, lat, bc);
    ref_div(4'd11, 4'd3, eq, er, edz, elat);
    n_cmp++;
    if ({q, r, dz} !== {eq, er, edz}) begin
      n_fail++;
      $display("FAIL basic_11_3: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
               q, r, dz, eq, er, edz);
    end
    n_cmp++;
    if (lat !== elat || bc !== W) begin
      n_fail++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
               lat, bc, elat, W);
    end
    n_cmp++;
    if ({done, quotient, remainder} !== {1'b0, eq, er}) begin
      n_fail++;
      $display("FAIL basic_hold: got done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d",
               done, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r, eq, er;
    logic dz, edz;
    int lat, elat, bc;
    issue(4'd15, 4'd1, q, r, dz, lat, bc);
    ref_div(4'd15, 4'd1, eq, er, edz, elat);
    n_cmp++;
    if ({q, r, dz} !== {eq, er, edz} || lat !== elat) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=%0d",
               q, r, lat, eq, er, elat);
    end
    issue(4'd5, 4'd9, q, r, dz, lat, bc);
    ref_div(4'd5, 4'd9, eq, er, edz, elat);
    n_cmp++;
    if ({q, r, dz} !== {eq, er, edz} || lat !== elat) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=%0d",
               q, r, lat, eq, er, elat);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r;
    logic dz;
    int lat, bc;
    issue(4'd13, 4'd0, q, r, dz, lat, bc);
    n_cmp++;
    if ({q, r, dz} !== {4'b1111, 4'b1101, 1'b1} || lat !== 1 || bc !== 0) begin
      n_fail++;
      $display("FAIL div_zero: got q=%b r=%b dz=%b lat=%0d busy=%0d, want 1111 1101 1 1 0",
               q, r, dz, lat, bc);
    end
    n_cmp++;
    if ({div_by_zero, quotient} !== {1'b1, 4'b1111}) begin
      n_fail++;
      $display("FAIL div_zero_hold: got dz=%b q=%b, want 1 1111", div_by_zero, quotient);
    end
    issue(4'd6, 4'd4, q, r, dz, lat, bc);
    n_cmp++;
    if ({q, r, dz} !== {4'd1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b, want 1 2 0", q, r, dz);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd6; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if ({quotient, remainder} !== {4'd4, 4'd1} || lat !== W + 1) begin
      n_fail++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want q=4 r=1 lat=%0d",
               quotient, remainder, lat, W + 1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_no_requeue: busy/done %b, want 00", {busy, done});
    end
  endtask

  task automatic test_async_reset;
    logic [W-1:0] q, r;
    logic dz;
    int lat, bc;
    issue(4'd13, 4'd2, q, r, dz, lat, bc);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_results: got q=%0d r=%0d, want 0 0", quotient, remainder);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: got %b, want all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state_idle: busy/done %b, want 00", {busy, done});
    end
    issue(4'd7, 4'd7, q, r, dz, lat, bc);
    n_cmp++;
    if ({q, r, dz} !== {4'd1, 4'd0, 1'b0} || lat !== W + 1) begin
      n_fail++;
      $display("FAIL after_reset_7_7: got q=%0d r=%0d lat=%0d, want 1 0 %0d",
               q, r, lat, W + 1);
    end
  endtask

  task automatic test_boundaries;
    logic [W-1:0] av [6] = '{4'd3, 4'd10, 4'd0, 4'd15, 4'd0, 4'd1};
    logic [W-1:0] bv [6] = '{4'd7, 4'd1, 4'd5, 4'd15, 4'd1, 4'd15};
    logic [W-1:0] q, r, eq, er;
    logic dz, edz;
    int lat, elat, bc;
    for (int i = 0; i < 6; i++) begin
      issue(av[i], bv[i], q, r, dz, lat, bc);
      ref_div(av[i], bv[i], eq, er, edz, elat);
      n_cmp++;
      if ({q, r, dz} !== {eq, er, edz} || lat !== elat) begin
        n_fail++;
        $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=%b lat=%0d",
                 av[i], bv[i], q, r, dz, lat, eq, er, edz, elat);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic dz, edz;
    int lat, elat, bc, gap;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      issue(a, b, q, r, dz, lat, bc);
      ref_div(a, b, eq, er, edz, elat);
      n_cmp++;
      if ({q, r, dz} !== {eq, er, edz} || lat !== elat) begin
        n_fail++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=%b lat=%0d",
                 a, b, q, r, dz, lat, eq, er, edz, elat);
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    logic [W-1:0] q, r;
    logic dz;
    int lat, bc;
    issue(4'b1001, 4'd2, q, r, dz, lat, bc);
    n_cmp++;
    if ({q, r} !== {4'b1101, 4'b1111} || lat !== W + 1) begin
      n_fail++;
      $display("FAIL signed_m7_2: got q=%b r=%b lat=%0d, want 1101 1111 %0d", q, r, lat, W + 1);
    end
    issue(4'b1000, 4'b1111, q, r, dz, lat, bc);
    n_cmp++;
    if ({q, r} !== {4'b1000, 4'b0000}) begin
      n_fail++;
      $display("FAIL signed_m8_m1: got q=%b r=%b, want 1000 0000", q, r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_async_reset();
    test_boundaries();
    test_random();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider: one quotient bit per clock.
- Each step runs a trial subtraction through an add/subtract datapath. On a borrow, the subtraction result is discarded and the partial remainder is kept (the restore).
- It is the iterative counterpart to the team's combinational ripple adder/subtractor. It sits beside that block in the arithmetic lab set and is driven by a start/done handshake from a testbench or control FSM.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured on accepted start
- divisor  input  WIDTH  denominator; captured on accepted start
- busy  output  1  high from the cycle after accept until done is asserted
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result; held until next accepted start
- remainder  output  WIDTH  result; held until next accepted start
- div_by_zero  output  1  set with done when divisor==0; held with the results

Behaviour:
- Interface:
  - One clock.
  - Reset is asynchronous and active-high, on ports clk and rst.
  - rst forces state=IDLE and busy, done, quotient, remainder, div_by_zero and all internal registers to 0, at any time including mid-division.
- States:
  - IDLE -> CALC on start && divisor!=0.
  - IDLE -> FIN on start && divisor==0.
  - CALC -> FIN when step count reaches WIDTH.
  - FIN -> IDLE unconditionally.
- Accept (IDLE && start):
  - Load Q=dividend, A=0 (WIDTH+1 bits), D=divisor, count=0.
  - Clear div_by_zero.
  - Clear quotient and remainder.
- CALC, each cycle:
  - Shift {A,Q} left by 1.
  - T = A_shifted - {1'b0,D}, computed through the add/sub sub-module (mode=1, two's complement).
  - If T[WIDTH]==1 (negative): A keeps A_shifted and Q[0]=0.
  - Else: A=T and Q[0]=1.
  - count increments.
  - Exactly WIDTH CALC cycles.
- FIN, one cycle:
  - done=1; quotient=Q; remainder=A[WIDTH-1:0].
  - Divide-by-zero path: quotient = all ones, remainder = dividend, div_by_zero=1.
- Latency:
  - Accept at edge N: done is high in cycle N+WIDTH+1.
  - Divide-by-zero: done is high in cycle N+1.
- Handshake:
  - start is ignored while busy or in FIN. No queuing and no abort.
  - start in the cycle after done is accepted normally (back-to-back operation).
- Boundaries:
  - dividend < divisor: quotient=0, remainder=dividend.
  - divisor=1: quotient=dividend, remainder=0.
  - dividend=0: quotient=0, remainder=0 with normal latency.
  - Max values (all ones / all ones): quotient=1, remainder=0.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - On accept, the magnitudes of dividend and divisor are captured and the two sign bits are registered.
  - In FIN, quotient is negated if the signs differ; remainder takes the sign of the dividend (truncating division).
  - The most-negative / -1 case wraps: quotient = 1 followed by zeros (4'b1000 at WIDTH=4), remainder 0.
  - Latency is unchanged. Divide-by-zero behaviour is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Shared package arith_pkg holds:
  - state enum (IDLE, CALC, FIN);
  - ADD_MODE=0, SUB_MODE=1 constants;
  - count-width function clog2(WIDTH+1).
- One sub-module, addsub_n:
  - Parameterised (WIDTH+1)-bit ripple adder/subtractor: b XORed with mode, carry-in = mode.
  - Instantiated once for the trial subtraction; under SIGNED_DIV_EN it is reused for the negations.

Test Plan:
- 11/3, WIDTH=4 -> quotient=4'b0011, remainder=4'b0010; done exactly 5 cycles after the accept edge; busy high for 4 cycles.
- 15/1 then 5/9, back-to-back starts -> (15,0) then (0,5); second start accepted the cycle after the first done.
- 13/0 -> done 1 cycle after accept; quotient=4'b1111, remainder=4'b1101, div_by_zero=1.
- 9/2 started, start pulsed again mid-CALC with 6/3 -> second start ignored; result (4,1).
- 14/3 started, rst asserted in CALC cycle 2 -> all outputs 0 immediately (asynchronous), state IDLE; a new 7/7 afterwards -> (1,0).
- SIGNED_DIV_EN defined: -7/2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1); -8/-1 -> quotient=4'b1000, remainder=0.
